step_threshold_tx: RTL and testbench

- Upstream producer for the step-activation stage of the neurosynapse datapath.
- Accepts a 32-bit IEEE-754 single-precision value (neuron weighted sum) over a STB/BUSY handshake and compares it against a threshold.
- Transmits the 1-bit fire decision (out_tp) over a second STB/BUSY handshake to the activation block, which turns it into 1.0/0.0.

---
 rtl/step_threshold_tx_if.sv | 43 ++++
 rtl/step_threshold_tx.sv | 123 ++++++++++++
 tb/tb_step_threshold_tx.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/step_threshold_tx_if.sv
// rtl/step_threshold_tx_if.sv - operand/decision handshake bundle for step_threshold_tx (optional out_nan under NAN_FLAG_EN)

interface step_threshold_tx_if;

    // Upstream operand channel (STB/BUSY)
    logic [31:0] in_x;
    logic        in_stb;
    logic        in_busy;

    // Downstream decision channel (STB/BUSY)
    logic        out_tp;
    logic        out_stb;
    logic        out_busy;

`ifdef NAN_FLAG_EN
    logic        out_nan;

    // Environment side: produces operands, consumes decisions
    modport master (
        output in_x, in_stb, out_busy,
        input  in_busy, out_tp, out_stb, out_nan
    );

    // Block side: consumes operands, produces decisions
    modport slave (
        input  in_x, in_stb, out_busy,
        output in_busy, out_tp, out_stb, out_nan
    );
`else
    // Environment side: produces operands, consumes decisions
    modport master (
        output in_x, in_stb, out_busy,
        input  in_busy, out_tp, out_stb
    );

    // Block side: consumes operands, produces decisions
    modport slave (
        input  in_x, in_stb, out_busy,
        output in_busy, out_tp, out_stb
    );
`endif

endinterface

// File: rtl/step_threshold_tx.sv
// rtl/step_threshold_tx.sv - float32 threshold compare, 1-bit fire decision over STB/BUSY (optional NaN flag: NAN_FLAG_EN)

module step_threshold_tx #(
    parameter logic [31:0] THRESHOLD = 32'h00000000,
    parameter bit          GE        = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    step_threshold_tx_if.slave bus
);

    // Maps a float32 bit pattern to an unsigned key whose integer order
    // matches numeric order. Both zeros collapse to the same key so that
    // -0 and +0 compare equal; negatives are bit-inverted so that larger
    // magnitudes sort lower.
    function automatic logic [31:0] order_key(input logic [31:0] v);
        logic [31:0] k;
        if (v[30:0] == 31'd0) begin
            k = 32'h8000_0000;
        end else if (!v[31]) begin
            k = {1'b1, v[30:0]};
        end else begin
            k = ~v;
        end
        return k;
    endfunction

    // All-ones exponent with a non-zero mantissa; infinities are not NaN.
    function automatic logic is_nan(input logic [31:0] v);
        return (&v[30:23]) && (|v[22:0]);
    endfunction

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COMPARE = 2'd1;
    localparam logic [1:0] ST_EMIT    = 2'd2;

    // The threshold is fixed per instance, so its key and NaN-ness fold to constants.
    localparam logic [31:0] THRESH_KEY = order_key(THRESHOLD);
    localparam logic        THRESH_NAN = is_nan(THRESHOLD);

    logic [1:0]  state;
    logic [31:0] x_r;
    logic        in_busy_r;
    logic        out_stb_r;
    logic        out_tp_r;
    logic        nan_r;

    logic [31:0] key_x;
    logic        x_nan;
    logic        above;
    logic        result;

    // Fire decision from the captured operand; any NaN on either side suppresses firing.
    always_comb begin
        key_x  = order_key(x_r);
        x_nan  = is_nan(x_r);
        above  = 1'b0;
        if (GE) begin
            above = (key_x >= THRESH_KEY);
        end else begin
            above = (key_x > THRESH_KEY);
        end
        result = above && !x_nan && !THRESH_NAN;
    end

    // Handshake FSM: capture in IDLE, decide in COMPARE, hold the decision in EMIT until taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            x_r       <= 32'd0;
            in_busy_r <= 1'b0;
            out_stb_r <= 1'b0;
            out_tp_r  <= 1'b0;
            nan_r     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.in_stb && !in_busy_r) begin
                        x_r       <= bus.in_x;
                        in_busy_r <= 1'b1;
                        state     <= ST_COMPARE;
                    end
                end
                ST_COMPARE: begin
                    out_tp_r  <= result;
                    nan_r     <= x_nan;
                    out_stb_r <= 1'b1;
                    state     <= ST_EMIT;
                end
                ST_EMIT: begin
                    // busy stays high through the transfer edge, so a new
                    // strobe arriving with the release is taken one edge later
                    if (out_stb_r && !bus.out_busy) begin
                        out_stb_r <= 1'b0;
                        in_busy_r <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    x_r       <= 32'd0;
                    in_busy_r <= 1'b0;
                    out_stb_r <= 1'b0;
                    out_tp_r  <= 1'b0;
                    nan_r     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_busy = in_busy_r;
    assign bus.out_stb = out_stb_r;
    assign bus.out_tp  = out_tp_r;

`ifdef NAN_FLAG_EN
    assign bus.out_nan = nan_r;
`else
    // Without the flag port the NaN register only follows the operand and is otherwise unused.
    logic unused_nan;
    assign unused_nan = nan_r;
`endif

endmodule

// File: tb/tb_step_threshold_tx.sv
// tb/tb_step_threshold_tx.sv - randomized self-checking bench for step_threshold_tx (four threshold/GE instances in lockstep)

module tb_step_threshold_tx;

    localparam logic [31:0] TH0 = 32'h0000_0000;  // +0.0, >=
    localparam logic [31:0] TH1 = 32'h0000_0000;  // +0.0, >
    localparam logic [31:0] TH2 = 32'hBF80_0000;  // -1.0, >=
    localparam logic [31:0] TH3 = 32'h7FC0_0001;  // NaN threshold
    localparam bit          GE0 = 1'b1;
    localparam bit          GE1 = 1'b0;
    localparam bit          GE2 = 1'b1;
    localparam bit          GE3 = 1'b1;

    logic        clk;
    logic        rst;
    logic [31:0] in_x;
    logic        in_stb;
    logic        out_busy;

    int n_cmp;
    int n_fail;

    step_threshold_tx_if if0 ();
    step_threshold_tx_if if1 ();
    step_threshold_tx_if if2 ();
    step_threshold_tx_if if3 ();

    assign if0.in_x = in_x;  assign if0.in_stb = in_stb;  assign if0.out_busy = out_busy;
    assign if1.in_x = in_x;  assign if1.in_stb = in_stb;  assign if1.out_busy = out_busy;
    assign if2.in_x = in_x;  assign if2.in_stb = in_stb;  assign if2.out_busy = out_busy;
    assign if3.in_x = in_x;  assign if3.in_stb = in_stb;  assign if3.out_busy = out_busy;

    step_threshold_tx #(.THRESHOLD(TH0), .GE(GE0)) u_dut0 (.clk(clk), .rst(rst), .bus(if0));
    step_threshold_tx #(.THRESHOLD(TH1), .GE(GE1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));
    step_threshold_tx #(.THRESHOLD(TH2), .GE(GE2)) u_dut2 (.clk(clk), .rst(rst), .bus(if2));
    step_threshold_tx #(.THRESHOLD(TH3), .GE(GE3)) u_dut3 (.clk(clk), .rst(rst), .bus(if3));

    logic [3:0] obs_busy;
    logic [3:0] obs_stb;
    logic [3:0] obs_tp;
    logic [3:0] obs_nan;

    assign obs_busy = {if3.in_busy, if2.in_busy, if1.in_busy, if0.in_busy};
    assign obs_stb  = {if3.out_stb, if2.out_stb, if1.out_stb, if0.out_stb};
    assign obs_tp   = {if3.out_tp,  if2.out_tp,  if1.out_tp,  if0.out_tp};
`ifdef NAN_FLAG_EN
    assign obs_nan  = {if3.out_nan, if2.out_nan, if1.out_nan, if0.out_nan};
`else
    assign obs_nan  = 4'h0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no summary, required completion");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model (numeric, via real arithmetic) ----------------

    function automatic bit ref_nan(input logic [31:0] v);
        return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
    endfunction

    function automatic real ref_value(input logic [31:0] v);
        int  e;
        real m;
        real r;
        e = int'(v[30:23]);
        if (e == 255) return v[31] ? -1.0e300 : 1.0e300;
        m = real'(v[22:0]);
        if (e == 0) e = 1;
        else        m = m + 8388608.0;
        r = m * (2.0 ** real'(e - 150));
        return v[31] ? -r : r;
    endfunction

    function automatic bit ref_fire(input logic [31:0] x, input logic [31:0] t, input bit ge);
        real rx, rt;
        if (ref_nan(x) || ref_nan(t)) return 1'b0;
        rx = ref_value(x);
        rt = ref_value(t);
        return ge ? (rx >= rt) : (rx > rt);
    endfunction

    function automatic logic [3:0] exp_tp(input logic [31:0] x);
        return {ref_fire(x, TH3, GE3), ref_fire(x, TH2, GE2),
                ref_fire(x, TH1, GE1), ref_fire(x, TH0, GE0)};
    endfunction

    function automatic logic [3:0] exp_nan(input logic [31:0] x);
`ifdef NAN_FLAG_EN
        return {4{ref_nan(x)}};
`else
        return 4'h0;
`endif
    endfunction

    function automatic logic [31:0] rand_val();
        logic [31:0] v;
        v = $urandom;
        case ($urandom_range(0, 7))
            0: v = {v[31], 31'd0};
            1: v = {v[31], 8'hFF, 23'd0};
            2: v = {v[31], 8'hFF, 23'($urandom_range(1, 32'h7F_FFFF))};
            3: v = {v[31], 8'h00, v[22:0]};
            4: v = 32'hBF80_0000 + 32'($urandom_range(0, 2)) - 32'd1;
            5: v = {v[31], 8'h7F, v[22:0]};
            default: ;
        endcase
        return v;
    endfunction

    // ---------------- scenarios ----------------

    task automatic test_reset();
        rst = 1'b1; in_stb = 1'b0; in_x = 32'd0; out_busy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (obs_busy !== 4'h0) begin $display("FAIL reset_in_busy got %b want 0000", obs_busy); n_fail++; end
        n_cmp++; if (obs_stb !== 4'h0)  begin $display("FAIL reset_out_stb got %b want 0000", obs_stb); n_fail++; end
        n_cmp++; if (obs_tp !== 4'h0)   begin $display("FAIL reset_out_tp got %b want 0000", obs_tp); n_fail++; end
        n_cmp++; if (obs_nan !== 4'h0)  begin $display("FAIL reset_out_nan got %b want 0000", obs_nan); n_fail++; end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    // One complete transaction; out_busy is held for 'hold' cycles once the decision is up.
    task automatic do_txn(input logic [31:0] x, input int hold, input string tag);
        int n;
        n = 0;
        while (obs_busy !== 4'h0 && n < 20) begin @(posedge clk); #1; n++; end
        n_cmp++; if (n >= 20) begin $display("FAIL %s idle_wait got busy=%b want 0000 within 20 cycles", tag, obs_busy); n_fail++; end
        in_x = x; in_stb = 1'b1; out_busy = (hold > 0);
        @(posedge clk); #1;
        in_stb = 1'b0; in_x = $urandom;
        n_cmp++; if (obs_busy !== 4'hF || obs_stb !== 4'h0) begin
            $display("FAIL %s accept got busy=%b stb=%b want 1111/0000", tag, obs_busy, obs_stb); n_fail++; end
        @(posedge clk); #1;
        n_cmp++; if (obs_stb !== 4'hF) begin $display("FAIL %s latency got stb=%b want 1111", tag, obs_stb); n_fail++; end
        n_cmp++; if (obs_tp !== exp_tp(x)) begin $display("FAIL %s out_tp x=%h got %b want %b", tag, x, obs_tp, exp_tp(x)); n_fail++; end
        n_cmp++; if (obs_nan !== exp_nan(x)) begin $display("FAIL %s out_nan x=%h got %b want %b", tag, x, obs_nan, exp_nan(x)); n_fail++; end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            n_cmp++; if (obs_stb !== 4'hF || obs_busy !== 4'hF || obs_tp !== exp_tp(x)) begin
                $display("FAIL %s hold stb=%b busy=%b tp=%b want 1111/1111/%b", tag, obs_stb, obs_busy, obs_tp, exp_tp(x)); n_fail++; end
        end
        out_busy = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (obs_stb !== 4'h0 || obs_busy !== 4'h0) begin
            $display("FAIL %s transfer got stb=%b busy=%b want 0000/0000", tag, obs_stb, obs_busy); n_fail++; end
    endtask

    task automatic test_vectors();
        do_txn(32'h3F80_0000, 0, "one");
        do_txn(32'hC020_0000, 0, "neg_2p5");
        do_txn(32'h0000_0001, 0, "min_denorm");
        do_txn(32'h8000_0000, 0, "neg_zero");
        do_txn(32'h0000_0000, 0, "pos_zero");
        do_txn(32'h7FC0_0000, 0, "qnan");
        do_txn(32'hFF80_0000, 0, "neg_inf");
        do_txn(32'h7F80_0000, 0, "pos_inf");
        do_txn(32'hBF80_0000, 0, "neg_one");
    endtask

    // in_stb held high: accepts every third edge, decision visible on the edge after each accept.
    task automatic test_back_to_back();
        logic [31:0] vals[6];
        logic [31:0] cur;
        int k;
        foreach (vals[i]) vals[i] = rand_val();
        out_busy = 1'b0;
        in_x = vals[0]; in_stb = 1'b1; k = 0; cur = vals[0];
        for (int j = 0; j < 18; j++) begin
            @(posedge clk); #1;
            if (j % 3 == 0) begin
                cur = vals[k];
                k++;
                if (k < 6) in_x = vals[k];
                else       in_stb = 1'b0;
            end
            n_cmp++; if (obs_busy !== ((j % 3 == 2) ? 4'h0 : 4'hF) || obs_stb !== ((j % 3 == 1) ? 4'hF : 4'h0)) begin
                $display("FAIL b2b edge%0d got busy=%b stb=%b", j, obs_busy, obs_stb); n_fail++; end
            if (j % 3 == 1) begin
                n_cmp++; if (obs_tp !== exp_tp(cur)) begin $display("FAIL b2b tp x=%h got %b want %b", cur, obs_tp, exp_tp(cur)); n_fail++; end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] a, b;
        a = 32'h3F80_0000; b = 32'hC020_0000;
        in_x = a; in_stb = 1'b1; out_busy = 1'b1;
        @(posedge clk); #1;
        in_x = b;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_cmp++; if (obs_stb !== 4'hF || obs_busy !== 4'hF || obs_tp !== exp_tp(a)) begin
                $display("FAIL bp_hold%0d stb=%b busy=%b tp=%b want 1111/1111/%b", i, obs_stb, obs_busy, obs_tp, exp_tp(a)); n_fail++; end
        end
        out_busy = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (obs_stb !== 4'h0 || obs_busy !== 4'h0) begin
            $display("FAIL bp_release got stb=%b busy=%b want 0000/0000", obs_stb, obs_busy); n_fail++; end
        @(posedge clk); #1;
        in_stb = 1'b0;
        n_cmp++; if (obs_busy !== 4'hF) begin $display("FAIL bp_accept_new got busy=%b want 1111", obs_busy); n_fail++; end
        @(posedge clk); #1;
        n_cmp++; if (obs_stb !== 4'hF || obs_tp !== exp_tp(b)) begin
            $display("FAIL bp_new_value got stb=%b tp=%b want 1111/%b", obs_stb, obs_tp, exp_tp(b)); n_fail++; end
        @(posedge clk); #1;
        n_cmp++; if (obs_stb !== 4'h0) begin $display("FAIL bp_new_transfer got stb=%b want 0000", obs_stb); n_fail++; end
    endtask

    task automatic test_reset_mid();
        // reset while deciding
        in_x = 32'h3F80_0000; in_stb = 1'b1; out_busy = 1'b1;
        @(posedge clk); #1;
        in_stb = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_cmp++; if (obs_stb !== 4'h0 || obs_busy !== 4'h0 || obs_tp !== 4'h0) begin
            $display("FAIL rst_compare got stb=%b busy=%b tp=%b want 0000/0000/0000", obs_stb, obs_busy, obs_tp); n_fail++; end
        // reset while emitting under backpressure
        in_x = 32'h3F80_0000; in_stb = 1'b1;
        @(posedge clk); #1;
        in_stb = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (obs_stb !== 4'hF) begin $display("FAIL rst_pre_emit got stb=%b want 1111", obs_stb); n_fail++; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; out_busy = 1'b0;
        n_cmp++; if (obs_stb !== 4'h0 || obs_busy !== 4'h0 || obs_tp !== 4'h0 || obs_nan !== 4'h0) begin
            $display("FAIL rst_emit got stb=%b busy=%b tp=%b nan=%b want all 0", obs_stb, obs_busy, obs_tp, obs_nan); n_fail++; end
        @(posedge clk); #1;
        n_cmp++; if (obs_stb !== 4'h0) begin $display("FAIL rst_lost_decision got stb=%b want 0000", obs_stb); n_fail++; end
        do_txn(32'h4000_0000, 0, "after_rst_two");
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            do_txn(rand_val(), int'($urandom_range(0, 3)), "rand");
        end
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        rst = 1'b1; in_stb = 1'b0; in_x = 32'd0; out_busy = 1'b0;
        test_reset();
        test_vectors();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
